// File: rtl/div_2in_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_2in_seq_if
//  Description : Start/valid handshake bundle for the sequential fixed-point
//                divider. master = requester, slave = divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_2in_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             o_busy;
    logic             o_ovf;
    logic             o_dz;

    modport master (
        output i_start, i_a, i_b,
        input  o, o_valid, o_busy, o_ovf, o_dz
    );

    modport slave (
        input  i_start, i_a, i_b,
        output o, o_valid, o_busy, o_ovf, o_dz
    );
endinterface
`default_nettype wire

// File: rtl/div_2in_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_2in_seq
//  Description : Sequential signed fixed-point divider, o = (a << FRAC) / b,
//                Q(WIDTH-FRAC).FRAC two's complement. Restoring division on
//                magnitudes, one quotient bit per cycle, then sign, optional
//                rounding and saturation. Divide-by-zero saturates and flags.
//                Optional feature macro: DIV_ROUND_EN (adds one guard
//                iteration and rounds half away from zero).
//  Revision    : 1.0  initial release
// ============================================================================
module div_2in_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  wire logic     clk,
    input  wire logic     rst,
    div_2in_seq_if.slave  bus
);

`ifdef DIV_ROUND_EN
    localparam int c_EXT = FRAC + 1;
`else
    localparam int c_EXT = FRAC;
`endif
    localparam int c_N  = WIDTH + c_EXT;
    localparam int c_CW = $clog2(c_N);

    localparam logic [c_CW-1:0]  c_CNT_LOAD = c_CW'(c_N - 1);
    localparam logic [c_N-1:0]   c_LIM_POS  = {{(c_N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [c_N-1:0]   c_LIM_NEG  = {{(c_N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CW-1:0]    r_cnt,   w_cnt_nxt;
    logic               r_sign,  w_sign_nxt;
    logic               r_a_neg, w_a_neg_nxt;
    logic               r_dz,    w_dz_nxt;
    logic [WIDTH-1:0]   r_babs,  w_babs_nxt;
    logic [c_N-1:0]     r_dvd,   w_dvd_nxt;
    logic [WIDTH-1:0]   r_rem,   w_rem_nxt;
    logic [c_N-1:0]     r_quo,   w_quo_nxt;
    logic [WIDTH-1:0]   r_o,     w_o_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_ovf,   w_ovf_nxt;
    logic               r_dz_o,  w_dz_o_nxt;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    assign w_a_abs = bus.i_a[WIDTH-1] ? -bus.i_a : bus.i_a;
    assign w_b_abs = bus.i_b[WIDTH-1] ? -bus.i_b : bus.i_b;

    // One restoring step. The remainder is always < |b| <= 2^(WIDTH-1), so
    // after the shift only bit WIDTH can exceed the low field; when it is set
    // the divisor certainly fits and the modular low-field difference is exact.
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sub;
    assign w_rem_sh  = {r_rem, r_dvd[c_N-1]};
    assign w_ge      = w_rem_sh[WIDTH] | (w_rem_sh[WIDTH-1:0] >= r_babs);
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_babs;

    // Final magnitude, rounded from the guard bit when enabled
    logic [c_N-1:0] w_q_mag;
`ifdef DIV_ROUND_EN
    assign w_q_mag = {1'b0, r_quo[c_N-1:1]} + {{(c_N-1){1'b0}}, r_quo[0]};
`else
    assign w_q_mag = r_quo;
`endif

    logic             w_sat;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;
    assign w_sat = w_q_mag > (r_sign ? c_LIM_NEG : c_LIM_POS);

    // Result selection: divide-by-zero, saturation, or signed magnitude
    always_comb begin
        w_res     = w_q_mag[WIDTH-1:0];
        w_res_ovf = 1'b0;
        if (r_dz) begin
            w_res = r_a_neg ? c_MIN : c_MAX;
        end else if (w_sat) begin
            w_res     = r_sign ? c_MIN : c_MAX;
            w_res_ovf = 1'b1;
        end else if (r_sign) begin
            w_res = -w_q_mag[WIDTH-1:0];
        end
    end

    // Next-state and next-register logic for the IDLE/CALC/FIX sequence
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sign_nxt  = r_sign;
        w_a_neg_nxt = r_a_neg;
        w_dz_nxt    = r_dz;
        w_babs_nxt  = r_babs;
        w_dvd_nxt   = r_dvd;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_o_nxt     = r_o;
        w_valid_nxt = 1'b0;
        w_ovf_nxt   = r_ovf;
        w_dz_o_nxt  = r_dz_o;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_sign_nxt  = bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
                    w_a_neg_nxt = bus.i_a[WIDTH-1];
                    w_dz_nxt    = (bus.i_b == '0);
                    w_babs_nxt  = w_b_abs;
                    w_dvd_nxt   = {w_a_abs, {c_EXT{1'b0}}};
                    w_rem_nxt   = '0;
                    w_quo_nxt   = '0;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_dvd_nxt = {r_dvd[c_N-2:0], 1'b0};
                w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                w_quo_nxt = {r_quo[c_N-2:0], w_ge};
                if (r_cnt == '0) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_FIX: begin
                w_o_nxt     = w_res;
                w_ovf_nxt   = w_res_ovf;
                w_dz_o_nxt  = r_dz;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_a_neg <= 1'b0;
            r_dz    <= 1'b0;
            r_babs  <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_o     <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_dz_o  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sign  <= w_sign_nxt;
            r_a_neg <= w_a_neg_nxt;
            r_dz    <= w_dz_nxt;
            r_babs  <= w_babs_nxt;
            r_dvd   <= w_dvd_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_o     <= w_o_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
            r_dz_o  <= w_dz_o_nxt;
        end
    end

    assign bus.o       = r_o;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = (r_state != ST_IDLE);
    assign bus.o_ovf   = r_ovf;
    assign bus.o_dz    = r_dz_o;

endmodule
`default_nettype wire
